// File: rtl/cache_mem_arb_pkg.sv
// Shared state encoding and master index constants for the cache refill read arbiter.
package cache_mem_arb_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t S_IDLE = 2'd0;
  localparam arb_state_t S_ADDR = 2'd1;
  localparam arb_state_t S_DATA = 2'd2;

  localparam int REQ_ICACHE = 0;
  localparam int REQ_DCACHE = 1;

endpackage

// File: rtl/cache_mem_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after the pointer, wrapping; one-hot and index out.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int k;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    k     = 0;
    for (int off = 0; off < N; off++) begin
      k = (int'(ptr_i) + off) % N;
      if (!any_o && req_i[k]) begin
        any_o    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = IW'(k);
      end
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one AXI read channel between the cache refill masters, one burst in flight at a time.
// Optional per-master grant/wait counters are built when CACHE_MEM_ARB_PERF_CNT_EN is defined.
//
// state  | meaning
// S_IDLE | pick a requester round-robin and latch its address fields
// S_ADDR | present latched request to memory until mem_arready
// S_DATA | route beats to the grantee; counter reaching 1 marks the last beat
module cache_mem_arbiter
  import cache_mem_arb_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int ID_WIDTH   = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_REQ-1:0]                    req_arvalid,
  input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]    req_araddr,
  input  logic [N_REQ-1:0][LEN_WIDTH-1:0]     req_arlen,
  input  logic [N_REQ-1:0][ID_WIDTH-1:0]      req_arid,
  output logic [N_REQ-1:0]                    req_arready,
  output logic [N_REQ-1:0]                    req_rvalid,
  output logic [N_REQ-1:0]                    req_rlast,
  output logic [DATA_WIDTH-1:0]               req_rdata,
  output logic                                mem_arvalid,
  output logic [ADDR_WIDTH-1:0]               mem_araddr,
  output logic [LEN_WIDTH-1:0]                mem_arlen,
  output logic [ID_WIDTH-1:0]                 mem_arid,
  input  logic                                mem_arready,
  input  logic                                mem_rvalid,
  input  logic [DATA_WIDTH-1:0]               mem_rdata,
  output logic                                mem_rready,
`ifdef CACHE_MEM_ARB_PERF_CNT_EN
  output logic [N_REQ-1:0][31:0]              perf_grants,
  output logic [N_REQ-1:0][31:0]              perf_wait_cycles,
`endif
  output logic                                err_unexpected_r
);

  localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW   = LEN_WIDTH + 1;

  arb_state_t            state_q, state_d;
  logic [IDXW-1:0]       ptr_q, ptr_d, grant_q, grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic [N_REQ-1:0]      pick_gnt;
  logic [IDXW-1:0]       pick_idx;
  logic                  pick_any;
  logic                  beat_last;

  rr_pick #(.N(N_REQ), .IW(IDXW)) u_rr_pick (
    .req_i (req_arvalid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign beat_last = (state_q == S_DATA) && mem_rvalid && (cnt_q == CW'(1));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    len_d   = len_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    err_d   = err_q | (mem_rvalid && (state_q != S_DATA));
    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          addr_d  = '0;
          len_d   = '0;
          id_d    = '0;
          for (int i = 0; i < N_REQ; i++) begin
            if (pick_gnt[i]) begin
              addr_d = addr_d | req_araddr[i];
              len_d  = len_d  | req_arlen[i];
              id_d   = id_d   | req_arid[i];
            end
          end
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (mem_arready) begin
          // a zero-length request still moves one beat
          cnt_d   = (len_q == '0) ? CW'(1) : {1'b0, len_q};
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (mem_rvalid) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_d = S_IDLE;
            ptr_d   = (grant_q == IDXW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    req_arready = '0;
    req_rvalid  = '0;
    req_rlast   = '0;
    if (state_q == S_ADDR) req_arready[grant_q] = mem_arready;
    if (state_q == S_DATA) begin
      req_rvalid[grant_q] = mem_rvalid;
      req_rlast[grant_q]  = beat_last;
    end
  end

  assign req_rdata        = rst ? '0 : mem_rdata;
  assign mem_arvalid      = (state_q == S_ADDR);
  assign mem_rready       = (state_q == S_DATA);
  assign mem_araddr       = addr_q;
  assign mem_arlen        = len_q;
  assign mem_arid         = id_q;
  assign err_unexpected_r = err_q;

`ifdef CACHE_MEM_ARB_PERF_CNT_EN
  logic [N_REQ-1:0][31:0] grants_q, waits_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grants_q <= '0;
      waits_q  <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if ((state_q == S_IDLE) && pick_gnt[i] && (grants_q[i] != '1))
          grants_q[i] <= grants_q[i] + 1'b1;
        if (req_arvalid[i] && !((state_q != S_IDLE) && (grant_q == IDXW'(i))) && (waits_q[i] != '1))
          waits_q[i] <= waits_q[i] + 1'b1;
      end
    end
  end

  assign perf_grants      = grants_q;
  assign perf_wait_cycles = waits_q;
`endif

  // the grantee must keep its request up until the address is accepted
  a_hold_arvalid: assert property (@(posedge clk) disable iff (rst)
    (state_q == S_ADDR) |-> req_arvalid[grant_q]);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomized and directed bench for cache_mem_arbiter against a cycle-level behavioural model.
module tb_cache_mem_arbiter;
  localparam int N = 2, AW = 26, DW = 32, LW = 8, IW = 4;

  logic                 clk, rst;
  logic [N-1:0]         req_arvalid;
  logic [N-1:0][AW-1:0] req_araddr;
  logic [N-1:0][LW-1:0] req_arlen;
  logic [N-1:0][IW-1:0] req_arid;
  logic [N-1:0]         req_arready, req_rvalid, req_rlast;
  logic [DW-1:0]        req_rdata;
  logic                 mem_arvalid, mem_arready, mem_rvalid, mem_rready, err_unexpected_r;
  logic [AW-1:0]        mem_araddr;
  logic [LW-1:0]        mem_arlen;
  logic [IW-1:0]        mem_arid;
  logic [DW-1:0]        mem_rdata;
`ifdef CACHE_MEM_ARB_PERF_CNT_EN
  logic [N-1:0][31:0]   perf_grants, perf_wait_cycles;
`endif

  cache_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .req_arvalid(req_arvalid), .req_araddr(req_araddr), .req_arlen(req_arlen), .req_arid(req_arid),
    .req_arready(req_arready), .req_rvalid(req_rvalid), .req_rlast(req_rlast), .req_rdata(req_rdata),
    .mem_arvalid(mem_arvalid), .mem_araddr(mem_araddr), .mem_arlen(mem_arlen), .mem_arid(mem_arid),
    .mem_arready(mem_arready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rready(mem_rready),
`ifdef CACHE_MEM_ARB_PERF_CNT_EN
    .perf_grants(perf_grants), .perf_wait_cycles(perf_wait_cycles),
`endif
    .err_unexpected_r(err_unexpected_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 address, 2 data
  int            m_phase, m_grant, m_ptr, m_left, m_len;
  bit            m_err;
  logic [AW-1:0] m_addr;
  logic [IW-1:0] m_id;
  int            rv_cnt[N], rl_cnt[N];
  logic [DW-1:0] last_d_data;
  int            grant_log[$];
  logic [N-1:0]  e_ar, e_rv, e_rl;
  bit            found;
`ifdef CACHE_MEM_ARB_PERF_CNT_EN
  int unsigned   m_pg[N], m_pw[N];
`endif

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_arvalid", 64'(mem_arvalid), 64'(0));
      chk("rst_arready", 64'(req_arready), 64'(0));
      chk("rst_rvalid",  64'(req_rvalid),  64'(0));
      chk("rst_rlast",   64'(req_rlast),   64'(0));
      chk("rst_rdata",   64'(req_rdata),   64'(0));
      chk("rst_rready",  64'(mem_rready),  64'(0));
      chk("rst_araddr",  64'(mem_araddr),  64'(0));
      chk("rst_err",     64'(err_unexpected_r), 64'(0));
      m_phase = 0; m_ptr = 0; m_grant = 0; m_left = 0; m_err = 0;
`ifdef CACHE_MEM_ARB_PERF_CNT_EN
      for (int i = 0; i < N; i++) begin
        chk("rst_perf_g", 64'(perf_grants[i]), 64'(0));
        chk("rst_perf_w", 64'(perf_wait_cycles[i]), 64'(0));
        m_pg[i] = 0; m_pw[i] = 0;
      end
`endif
    end else begin
      e_ar = '0; e_rv = '0; e_rl = '0;
      if (m_phase == 1) e_ar[m_grant] = mem_arready;
      if (m_phase == 2) begin
        e_rv[m_grant] = mem_rvalid;
        e_rl[m_grant] = mem_rvalid && (m_left == 1);
      end
      chk("arvalid", 64'(mem_arvalid), 64'(m_phase == 1));
      chk("arready", 64'(req_arready), 64'(e_ar));
      chk("rvalid",  64'(req_rvalid),  64'(e_rv));
      chk("rlast",   64'(req_rlast),   64'(e_rl));
      chk("rdata",   64'(req_rdata),   64'(mem_rdata));
      chk("rready",  64'(mem_rready),  64'(m_phase == 2));
      chk("err",     64'(err_unexpected_r), 64'(m_err));
      if (m_phase == 1) begin
        chk("araddr", 64'(mem_araddr), 64'(m_addr));
        chk("arlen",  64'(mem_arlen),  64'(m_len));
        chk("arid",   64'(mem_arid),   64'(m_id));
      end
`ifdef CACHE_MEM_ARB_PERF_CNT_EN
      for (int i = 0; i < N; i++) begin
        chk("perf_grants", 64'(perf_grants[i]), 64'(m_pg[i]));
        chk("perf_wait",   64'(perf_wait_cycles[i]), 64'(m_pw[i]));
        if (req_arvalid[i] && !(m_phase != 0 && m_grant == i)) m_pw[i]++;
      end
`endif
      if (req_arready != '0) grant_log.push_back(req_arready[1] ? 1 : 0);
      for (int i = 0; i < N; i++) begin
        if (req_rvalid[i]) rv_cnt[i]++;
        if (req_rlast[i])  rl_cnt[i]++;
      end
      if (req_rlast[1]) last_d_data = req_rdata;

      if (mem_rvalid && m_phase != 2) m_err = 1;
      case (m_phase)
        0: begin
          found = 0;
          for (int k = 0; k < N; k++) begin
            if (!found && req_arvalid[(m_ptr + k) % N]) begin
              found   = 1;
              m_grant = (m_ptr + k) % N;
            end
          end
          if (found) begin
            m_addr  = req_araddr[m_grant];
            m_len   = int'(req_arlen[m_grant]);
            m_id    = req_arid[m_grant];
            m_phase = 1;
`ifdef CACHE_MEM_ARB_PERF_CNT_EN
            m_pg[m_grant]++;
`endif
          end
        end
        1: if (mem_arready) begin
          m_left  = (m_len == 0) ? 1 : m_len;
          m_phase = 2;
        end
        default: if (mem_rvalid) begin
          if (m_left == 1) begin
            m_phase = 0;
            m_ptr   = (m_grant + 1) % N;
          end else m_left--;
        end
      endcase
    end
  end

  // Stimulus: masters and memory
  bit           auto_req, auto_mem;
  int           req_pct, mem_left;
  logic [N-1:0] busy, acc_seen;

  task automatic tick();
    logic [N-1:0]  last;
    logic          beat, aacc;
    logic [LW-1:0] alen;
    @(negedge clk); #1;
    acc_seen = req_arready;
    last     = req_rlast;
    beat     = mem_rvalid && mem_rready;
    aacc     = mem_arvalid && mem_arready;
    alen     = mem_arlen;
    @(posedge clk); #1;
    if (rst) return;
    for (int i = 0; i < N; i++) begin
      if (acc_seen[i]) begin req_arvalid[i] = 1'b0; busy[i] = 1'b1; end
      if (last[i]) busy[i] = 1'b0;
      if (auto_req && !req_arvalid[i] && !busy[i] && ($urandom_range(0, 99) < req_pct)) begin
        req_arvalid[i] = 1'b1;
        req_araddr[i]  = AW'($urandom);
        req_arlen[i]   = LW'($urandom_range(0, 6));
        req_arid[i]    = IW'($urandom);
      end
    end
    if (auto_mem) begin
      if (beat) mem_left--;
      if (aacc) mem_left = (alen == 0) ? 1 : int'(alen);
      mem_arready = 1'($urandom_range(0, 1));
      mem_rvalid  = (mem_left > 0) && ($urandom_range(0, 2) != 0);
      mem_rdata   = $urandom;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_arvalid = '0; mem_rvalid = 1'b0; mem_arready = 1'b0;
    busy = '0; mem_left = 0; auto_req = 0; auto_mem = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin rv_cnt[i] = 0; rl_cnt[i] = 0; end
    grant_log.delete();
    rst = 1'b0;
  endtask

  task automatic drive_req(input int i, input logic [AW-1:0] a, input int len, input int id);
    req_arvalid[i] = 1'b1;
    req_araddr[i]  = a;
    req_arlen[i]   = LW'(len);
    req_arid[i]    = IW'(id);
  endtask

  task automatic wait_acc(input int i);
    int n = 0;
    do begin tick(); n++; end while (!acc_seen[i] && n < 20);
    chk("acc_timeout", 64'(acc_seen[i]), 64'(1));
  endtask

  task automatic beats(input int n, input logic [DW-1:0] base);
    for (int k = 0; k < n; k++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = base + DW'(k);
      tick();
    end
    mem_rvalid = 1'b0;
  endtask

  initial begin
    int n;
    req_araddr = '0; req_arlen = '0; req_arid = '0; mem_rdata = '0;
    do_reset();

    // single d_cache burst
    drive_req(1, 26'h0000100, 4, 8);
    #1;
    chk("A_idle_arready", 64'(req_arready), 64'(0));
    chk("A_idle_arvalid", 64'(mem_arvalid), 64'(0));
    tick();
    chk("A_arvalid_t1", 64'(mem_arvalid), 64'(1));
    tick();
    chk("A_araddr", 64'(mem_araddr), 64'h100);
    chk("A_arlen",  64'(mem_arlen),  64'(4));
    chk("A_arid",   64'(mem_arid),   64'(8));
    mem_arready = 1'b1;
    tick();
    chk("A_acc_t2", 64'(acc_seen), 64'b10);
    mem_arready = 1'b0;
    beats(4, 32'hA0);
    tick();
    chk("A_rv_d",   64'(rv_cnt[1]), 64'(4));
    chk("A_rl_d",   64'(rl_cnt[1]), 64'(1));
    chk("A_rv_i",   64'(rv_cnt[0]), 64'(0));
    chk("A_lastdat", 64'(last_d_data), 64'hA3);

    // both masters from reset release, sustained alternation
    do_reset();
    auto_req = 1; req_pct = 100; auto_mem = 1;
    n = 0;
    while (grant_log.size() < 4 && n < 400) begin tick(); n++; end
    chk("B_grants_seen", 64'(grant_log.size() >= 4), 64'(1));
    for (int k = 0; k < 4 && k < grant_log.size(); k++)
      chk("B_grant_order", 64'(grant_log[k]), 64'(k % 2));

    // zero-length request
    do_reset();
    mem_arready = 1'b1;
    drive_req(0, 26'h0000200, 0, 3);
    wait_acc(0);
    beats(1, 32'h77);
    chk("C_rl_i",   64'(rl_cnt[0]), 64'(1));
    chk("C_rv_i",   64'(rv_cnt[0]), 64'(1));
    chk("C_idle",   64'(mem_rready), 64'(0));

    // stray beat in idle
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD;
    #1;
    chk("D_no_rvalid", 64'(req_rvalid), 64'(0));
    tick();
    mem_rvalid = 1'b0;
    chk("D_err_set", 64'(err_unexpected_r), 64'(1));
    repeat (5) tick();
    chk("D_err_sticky", 64'(err_unexpected_r), 64'(1));

    // reset in the middle of a burst, pointer must restart at 0
    do_reset();
    mem_arready = 1'b1;
    drive_req(0, 26'h0000300, 1, 1);
    wait_acc(0);
    beats(1, 32'h10);
    drive_req(1, 26'h0000400, 4, 2);
    wait_acc(1);
    mem_rvalid = 1'b1; mem_rdata = 32'h20; tick();
    mem_rdata = 32'h21; tick();
    mem_rdata = 32'h55;
    rst = 1'b1;
    #1;
    chk("E_async_rvalid", 64'(req_rvalid), 64'(0));
    chk("E_async_rlast",  64'(req_rlast),  64'(0));
    chk("E_async_rready", 64'(mem_rready), 64'(0));
    chk("E_async_rdata",  64'(req_rdata),  64'(0));
    do_reset();
    mem_arready = 1'b1;
    drive_req(0, 26'h0000500, 2, 4);
    drive_req(1, 26'h0000600, 2, 5);
    tick(); tick();
    chk("E_ptr0_grant", 64'(acc_seen), 64'b01);
    beats(2, 32'h30);
    wait_acc(1);
    beats(2, 32'h40);
    tick();

    // randomized traffic
    do_reset();
    auto_req = 1; req_pct = 60; auto_mem = 1;
    repeat (3000) tick();

`ifdef CACHE_MEM_ARB_PERF_CNT_EN
    do_reset();
    mem_arready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      drive_req(1, 26'h0001000, 2, 6);
      wait_acc(1);
      beats(2, 32'h60);
    end
    tick();
    chk("F_grants_d_pre", 64'(perf_grants[1]), 64'(2));
    chk("F_wait_d_pre",   64'(perf_wait_cycles[1]), 64'(2));
    drive_req(0, 26'h0002000, 2, 7);
    drive_req(1, 26'h0003000, 2, 9);
    wait_acc(0);
    beats(2, 32'h70);
    wait_acc(1);
    beats(2, 32'h80);
    tick();
    chk("F_grants_i", 64'(perf_grants[0]), 64'(1));
    chk("F_grants_d", 64'(perf_grants[1]), 64'(3));
    chk("F_wait_i",   64'(perf_wait_cycles[0]), 64'(1));
    chk("F_wait_d",   64'(perf_wait_cycles[1]), 64'(7));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
